// File: rtl/haku_alu_pkg.sv
`default_nettype none
// =============================================================================
// Package  : haku_alu_pkg
// Brief    : Shared constants for the FP16 ALU array and its clients.
// Revision : 1.0 - initial release
// =============================================================================
package haku_alu_pkg;

  // Array geometry: 16 lanes of IEEE half precision
  localparam int LANES           = 16;
  localparam int LANE_W          = 16;
  localparam int DATA_W          = LANES * LANE_W;
  localparam int OPMODE_W        = 6;
  localparam int DEF_ALU_LATENCY = 5;

  // Arithmetic opmodes
  localparam logic [OPMODE_W-1:0] OP_FMA     = 6'b000000;
  localparam logic [OPMODE_W-1:0] OP_FMS     = 6'b000001;
  localparam logic [OPMODE_W-1:0] OP_INV_FMA = 6'b000010;
  localparam logic [OPMODE_W-1:0] OP_LOG     = 6'b000011;
  localparam logic [OPMODE_W-1:0] OP_EXP     = 6'b000100;

  // Compare prefixes; the low bits select the compare variant
  localparam logic [OPMODE_W-1:0] CMP_ZERO   = 6'b100000;
  localparam logic [OPMODE_W-1:0] CMP_POS    = 6'b101000;
  localparam logic [OPMODE_W-1:0] CMP_NEG    = 6'b110000;

  // Handy FP16 literals
  localparam logic [LANE_W-1:0]   FP16_ONE   = 16'h3C00;
  localparam logic [LANE_W-1:0]   FP16_ZERO  = 16'h0000;

endpackage : haku_alu_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter; the requester after the last winner gets
//            top priority next time. Grant is combinational and one-hot.
// Revision : 1.0 - initial release
// =============================================================================
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int c_pw = (N > 1) ? $clog2(N) : 1;

  logic [c_pw-1:0] r_ptr;
  logic [c_pw-1:0] w_gnt_idx;

  // Scan requesters starting at the priority pointer, take the first one
  always_comb begin
    int idx;
    grant     = '0;
    w_gnt_idx = '0;
    idx       = 0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        idx = (int'(r_ptr) + i) % N;
        if (grant == '0 && req[idx]) begin
          grant[idx] = 1'b1;
          w_gnt_idx  = c_pw'(idx);
        end
      end
    end
  end

  // Move priority to the requester just after the winner
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (grant != '0) begin
      r_ptr <= (w_gnt_idx == c_pw'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fp16_alu_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : fp16_alu_scheduler
// Brief    : Shares one FP16 ALU array between NUM_REQ requesters. Beats are
//            issued round-robin only when a response slot is already reserved,
//            tagged with their owner, and returned in issue order via a FIFO.
// Revision : 1.0 - initial release
// =============================================================================
module fp16_alu_scheduler
  import haku_alu_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ALU_LATENCY = DEF_ALU_LATENCY,
  parameter int RSP_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*OPMODE_W-1:0]  req_opmode,
  input  logic [NUM_REQ*DATA_W-1:0]    req_a,
  input  logic [NUM_REQ*DATA_W-1:0]    req_b,
  input  logic [NUM_REQ*DATA_W-1:0]    req_c,
  output logic                         alu_in_valid,
  output logic [OPMODE_W-1:0]          alu_opmode,
  output logic [DATA_W-1:0]            alu_a,
  output logic [DATA_W-1:0]            alu_b,
  output logic [DATA_W-1:0]            alu_c,
  input  logic [DATA_W-1:0]            alu_out,
  input  logic                         alu_out_valid,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         err_orphan
);

  localparam int c_idw = $clog2(NUM_REQ);
  localparam int c_ow  = $clog2(RSP_DEPTH + 1);
  localparam int c_pw  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  // ---------------------------------------------------------------------------
  // Credit accounting: a beat holds a response slot from grant until pop
  // ---------------------------------------------------------------------------
  logic [c_ow-1:0]    r_outstanding;
  logic               w_issue_ok;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_issue;
  logic               w_pop;

  assign w_issue_ok = (r_outstanding < c_ow'(RSP_DEPTH));
  assign w_issue    = |w_grant;
  assign w_pop      = rsp_valid && rsp_ready;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .en    (w_issue_ok && !rst),
    .grant (w_grant)
  );

  assign req_ready = w_grant;

  // Count beats issued but not yet consumed; an orphan pop never underflows it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
    end else if (w_issue && !(w_pop && r_outstanding != '0)) begin
      r_outstanding <= r_outstanding + 1'b1;
    end else if (!w_issue && w_pop && r_outstanding != '0) begin
      r_outstanding <= r_outstanding - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue stage: select the winner's operands
  // ---------------------------------------------------------------------------
  logic [OPMODE_W-1:0] w_sel_op;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [DATA_W-1:0]   w_sel_c;
  logic [c_idw-1:0]    w_sel_id;
  logic [c_idw-1:0]    r_issue_id;

  // One-hot mux of the granted requester's operands and its index
  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_c  = '0;
    w_sel_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_op = req_opmode[k*OPMODE_W +: OPMODE_W];
        w_sel_a  = req_a[k*DATA_W +: DATA_W];
        w_sel_b  = req_b[k*DATA_W +: DATA_W];
        w_sel_c  = req_c[k*DATA_W +: DATA_W];
        w_sel_id = c_idw'(k);
      end
    end
  end

  // Operand registers feeding the array; data holds when nothing is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_in_valid <= 1'b0;
      alu_opmode   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_c        <= '0;
      r_issue_id   <= '0;
    end else begin
      alu_in_valid <= w_issue;
      if (w_issue) begin
        alu_opmode <= w_sel_op;
        alu_a      <= w_sel_a;
        alu_b      <= w_sel_b;
        alu_c      <= w_sel_c;
        r_issue_id <= w_sel_id;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipe: follows each beat through the array so the result knows its owner
  // ---------------------------------------------------------------------------
  logic [ALU_LATENCY-1:0] r_tag_v;
  logic [c_idw-1:0]       r_tag_id [ALU_LATENCY];
  logic                   w_tag_v;
  logic [c_idw-1:0]       w_push_id;

  // Shift every cycle: the array never stalls, so neither does the tag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int i = 0; i < ALU_LATENCY; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_v[0]  <= alu_in_valid;
      r_tag_id[0] <= r_issue_id;
      for (int i = 1; i < ALU_LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  assign w_tag_v   = r_tag_v[ALU_LATENCY-1];
  assign w_push_id = w_tag_v ? r_tag_id[ALU_LATENCY-1] : '0;

  // Sticky flag for a result that has no matching tag
  always_ff @(posedge clk) begin
    if (rst) begin
      err_orphan <= 1'b0;
    end else if (alu_out_valid && !w_tag_v) begin
      err_orphan <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem_data [RSP_DEPTH];
  logic [c_idw-1:0]  r_mem_id   [RSP_DEPTH];
  logic [c_pw-1:0]   r_wr_ptr;
  logic [c_pw-1:0]   r_rd_ptr;
  logic [c_ow-1:0]   r_count;
  logic              w_full;
  logic              w_push;

  assign w_full    = (r_count == c_ow'(RSP_DEPTH));
  assign w_push    = alu_out_valid && !w_full;
  assign rsp_valid = (r_count != '0);
  assign rsp_id    = rsp_valid ? r_mem_id[r_rd_ptr]   : '0;
  assign rsp_data  = rsp_valid ? r_mem_data[r_rd_ptr] : '0;

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= alu_out;
      r_mem_id[r_wr_ptr]   <= w_push_id;
    end
  end

  // Pointers wrap at RSP_DEPTH; occupancy tracks push minus pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_pw'(RSP_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_pw'(RSP_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Credit scheme guarantees a result always finds a free slot
  always_ff @(posedge clk) begin
    if (!rst && alu_out_valid) begin
      assert (!w_full);
    end
  end

endmodule : fp16_alu_scheduler
`default_nettype wire
